// File: rtl/branch_pkg.sv
// rtl/branch_pkg.sv - branch op encoding, funct3 conditions and counter init helper
package branch_pkg;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_JUMP = 2'b01,
    BR_COND = 2'b10,
    BR_RSVD = 2'b11
  } branch_op_e;

  // Flag conventions: C is the ARM-style carry (set = no borrow on compare)
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Weakly not-taken: one below the taken threshold
  function automatic int ctr_init(input int ctr_w);
    return (1 << (ctr_w - 1)) - 1;
  endfunction

endpackage

// File: rtl/branch_resolve.sv
// rtl/branch_resolve.sv - combinational branch condition evaluator
module branch_resolve
  import branch_pkg::*;
(
  input  logic [1:0] i_branch_op,
  input  logic [2:0] i_funct3,
  input  logic       i_n,
  input  logic       i_z,
  input  logic       i_c,
  input  logic       i_v,
  output logic       o_taken,
  output logic       o_legal
);

  always_comb begin
    o_taken = 1'b0;
    o_legal = 1'b1;
    case (branch_op_e'(i_branch_op))
      BR_JUMP: o_taken = 1'b1;
      BR_COND: begin
        case (i_funct3)
          F3_BEQ:  o_taken = i_z;
          F3_BNE:  o_taken = ~i_z;
          F3_BLT:  o_taken = i_n ^ i_v;
          F3_BGE:  o_taken = ~(i_n ^ i_v);
          F3_BLTU: o_taken = ~i_c;
          F3_BGEU: o_taken = i_c;
          default: o_legal = 1'b0;
        endcase
      end
      default: o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - bimodal counters + tagged target buffer with execute-stage resolution
// Optional gshare counter indexing is enabled with BP_GSHARE_EN.
module branch_predictor
  import branch_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int IDX_W  = 6,
  parameter int TAG_W  = 8,
  parameter int CTR_W  = 2,
  parameter int HIST_W = 6
)
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] PCF,
  output logic             PredTakenF,
  output logic [WIDTH-1:0] PredTargetF,
  input  logic             ValidE,
  input  logic [1:0]       BranchOpE,
  input  logic [2:0]       funct3E,
  input  logic             N,
  input  logic             Z,
  input  logic             C,
  input  logic             V,
  input  logic [WIDTH-1:0] PCE,
  input  logic [WIDTH-1:0] PCTargetE,
  input  logic [WIDTH-1:0] PCPlus4E,
  input  logic             PredTakenE,
  input  logic [WIDTH-1:0] PredTargetE,
`ifdef BP_GSHARE_EN
  input  logic [HIST_W-1:0] GhrE,
`endif
  output logic             PCSrcE,
  output logic             MispredictE,
  output logic [WIDTH-1:0] RedirectPCE
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(ctr_init(CTR_W));
  localparam logic [CTR_W-1:0] CTR_MAX  = '1;

  logic             r_valid [ENTRIES];
  logic [TAG_W-1:0] r_tag   [ENTRIES];
  logic [WIDTH-1:0] r_tgt   [ENTRIES];
  logic [CTR_W-1:0] r_ctr   [ENTRIES];

  logic [IDX_W-1:0] w_idx_f, w_idx_e, w_cidx_f, w_cidx_e;
  logic [TAG_W-1:0] w_tag_f, w_tag_e;
  logic             w_taken, w_legal, w_is_br, w_train;
  logic             w_unused;
  branch_op_e       w_op;

  assign w_idx_f = PCF[IDX_W+1:2];
  assign w_idx_e = PCE[IDX_W+1:2];
  assign w_tag_f = PCF[IDX_W+TAG_W+1:IDX_W+2];
  assign w_tag_e = PCE[IDX_W+TAG_W+1:IDX_W+2];
  assign w_unused = ^{PCF[1:0], PCF[WIDTH-1:IDX_W+TAG_W+2], PCE[1:0], PCE[WIDTH-1:IDX_W+TAG_W+2]};

`ifdef BP_GSHARE_EN
  logic [HIST_W-1:0] r_ghr;
  // History sits in the top bits of the counter index; execute uses the fetch-time snapshot
  assign w_cidx_f = w_idx_f ^ (IDX_W'(r_ghr) << (IDX_W - HIST_W));
  assign w_cidx_e = w_idx_e ^ (IDX_W'(GhrE) << (IDX_W - HIST_W));
`else
  assign w_cidx_f = w_idx_f;
  assign w_cidx_e = w_idx_e;
`endif

  branch_resolve u_resolve (
    .i_branch_op (BranchOpE),
    .i_funct3    (funct3E),
    .i_n         (N),
    .i_z         (Z),
    .i_c         (C),
    .i_v         (V),
    .o_taken     (w_taken),
    .o_legal     (w_legal)
  );

  assign w_op    = branch_op_e'(BranchOpE);
  assign w_is_br = ValidE & ((w_op == BR_JUMP) | (w_op == BR_COND));
  assign w_train = w_is_br & w_legal;

  assign PCSrcE      = w_taken;
  assign RedirectPCE = w_taken ? PCTargetE : PCPlus4E;
  assign MispredictE = reset_n & w_train &
                       ((w_taken != PredTakenE) | (w_taken & (PredTargetE != PCTargetE)));

  assign PredTakenF  = reset_n & r_valid[w_idx_f] & (r_tag[w_idx_f] == w_tag_f) &
                       r_ctr[w_cidx_f][CTR_W-1];
  assign PredTargetF = reset_n ? r_tgt[w_idx_f] : '0;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
        r_tag[i]   <= '0;
        r_tgt[i]   <= '0;
        r_ctr[i]   <= CTR_INIT;
      end
`ifdef BP_GSHARE_EN
      r_ghr <= '0;
`endif
    end else if (w_train) begin
      if (w_taken) begin
        if (r_ctr[w_cidx_e] != CTR_MAX) r_ctr[w_cidx_e] <= r_ctr[w_cidx_e] + 1'b1;
        r_valid[w_idx_e] <= 1'b1;
        r_tag[w_idx_e]   <= w_tag_e;
        r_tgt[w_idx_e]   <= PCTargetE;
      end else if (r_ctr[w_cidx_e] != '0) begin
        r_ctr[w_cidx_e] <= r_ctr[w_cidx_e] - 1'b1;
      end
`ifdef BP_GSHARE_EN
      if (w_op == BR_COND) r_ghr <= (r_ghr << 1) | HIST_W'(w_taken);
`endif
    end
  end

endmodule
